// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with wrap/saturate modes, sync clear/load and status flags.
// Optional enable prescaler is compiled in with `define UDCNT_PRESCALE_EN.
module updown_mod_counter #(
  parameter int WIDTH        = 8,
  parameter int MAX_VAL      = 2**WIDTH-1,
  parameter int PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ldvalue,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  if (WIDTH < 2) begin : g_chk_w
    $error("WIDTH must be >= 2");
  end
  if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH-1) begin : g_chk_max
    $error("MAX_VAL out of range");
  end
  if (PRESCALE_DIV < 1) begin : g_chk_div
    $error("PRESCALE_DIV must be >= 1");
  end

  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             step;

`ifdef UDCNT_PRESCALE_EN
  localparam int PS_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV-1);

  logic [PS_W-1:0] ps_q, ps_d;

  // DIV=1 gives a 1-bit prescaler stuck at 0 == PS_LAST, so every enabled edge steps.
  assign step = en && (ps_q == PS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ps_q <= '0;
    else     ps_q <= ps_d;
  end

  always_comb begin
    ps_d = ps_q;
    if (clr || ld)  ps_d = '0;
    else if (step)  ps_d = '0;
    else if (en)    ps_d = ps_q + 1'b1;
  end
`else
  assign step = en;
`endif

  always_comb begin
    dout_d = dout_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (clr) begin
      dout_d = '0;
      ovf_d  = 1'b0;
    end else if (ld) begin
      dout_d = (ldvalue > MAX_V) ? MAX_V : ldvalue;
    end else if (step) begin
      if (up) begin
        if (dout_q == MAX_V) begin
          ovf_d = 1'b1;
          if (!sat) begin
            dout_d = '0;
            wrap_d = 1'b1;
          end
        end else begin
          dout_d = dout_q + 1'b1;
        end
      end else begin
        if (dout_q == '0) begin
          ovf_d = 1'b1;
          if (!sat) begin
            dout_d = MAX_V;
            wrap_d = 1'b1;
          end
        end else begin
          dout_d = dout_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout = dout_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;
  assign tc   = up ? (dout_q == MAX_V) : (dout_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed vector bench for updown_mod_counter at WIDTH=4, MAX_VAL=9.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst, clr, ld, en, up, sat;
  logic [3:0] ldvalue;
  logic [3:0] dout;
  logic       tc, wrap, ovf;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE_DIV(3)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ldvalue(ldvalue),
    .en(en), .up(up), .sat(sat), .dout(dout), .tc(tc), .wrap(wrap), .ovf(ovf)
  );

  typedef struct {
    logic       rst, clr, ld;
    logic [3:0] ldv;
    logic       en, up, sat;
    logic [3:0] d;
    logic       tc, wr, ov;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic l, input logic [3:0] lv,
                       input logic e, input logic u, input logic s);
    rst = r; clr = c; ld = l; ldvalue = lv; en = e; up = u; sat = s;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset dout", 32'(dout), 0);
    chk("reset wrap", 32'(wrap), 0);
    chk("reset ovf",  32'(ovf),  0);
    chk("reset tc",   32'(tc),   0);
    drive(0, 0, 0, 0, 0, 1, 0);

`ifndef UDCNT_PRESCALE_EN
    //                rst clr ld ldv en up sat   d tc wr ov
    vecs.push_back('{1, 0, 0, 0,  0, 1, 0,  0, 0, 0, 0});
    // up-wrap, 12 cycles
    vecs.push_back('{0, 0, 0, 0,  1, 1, 0,  1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 1, 0,  2, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 1, 0,  3, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 1, 0,  4, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 1, 0,  5, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 1, 0,  6, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 1, 0,  7, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 1, 0,  8, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 1, 0,  9, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 1, 0,  0, 0, 1, 1});
    vecs.push_back('{0, 0, 0, 0,  1, 1, 0,  1, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 0,  1, 1, 0,  2, 0, 0, 1});
    // down-saturate
    vecs.push_back('{0, 1, 0, 0,  0, 0, 1,  0, 1, 0, 0});
    vecs.push_back('{0, 0, 1, 2,  0, 0, 1,  2, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 0, 1,  1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 0, 1,  0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 0, 1,  0, 1, 0, 1});
    vecs.push_back('{0, 0, 0, 0,  1, 0, 1,  0, 1, 0, 1});
    vecs.push_back('{0, 0, 0, 0,  1, 0, 1,  0, 1, 0, 1});
    // load clamp beats step; clear beats load
    vecs.push_back('{0, 0, 1, 13, 1, 1, 0,  9, 1, 0, 1});
    vecs.push_back('{0, 1, 1, 5,  1, 1, 0,  0, 0, 0, 0});
    // down-wrap with enable gap
    vecs.push_back('{0, 0, 0, 0,  1, 0, 0,  9, 0, 1, 1});
    vecs.push_back('{0, 0, 0, 0,  0, 0, 0,  9, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 0,  1, 0, 0,  8, 0, 0, 1});
    // up-saturate, then tc follows direction with en=0
    vecs.push_back('{0, 1, 0, 0,  0, 1, 1,  0, 0, 0, 0});
    vecs.push_back('{0, 0, 1, 8,  0, 1, 1,  8, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 1, 1,  9, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0,  1, 1, 1,  9, 1, 0, 1});
    vecs.push_back('{0, 0, 0, 0,  0, 0, 1,  9, 0, 0, 1});
    // load does not disturb sticky ovf
    vecs.push_back('{0, 0, 1, 0,  0, 0, 0,  0, 1, 0, 1});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].ld, vecs[i].ldv, vecs[i].en, vecs[i].up, vecs[i].sat);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d dout", i), 32'(dout), 32'(vecs[i].d));
      chk($sformatf("v%0d tc", i),   32'(tc),   32'(vecs[i].tc));
      chk($sformatf("v%0d wrap", i), 32'(wrap), 32'(vecs[i].wr));
      chk($sformatf("v%0d ovf", i),  32'(ovf),  32'(vecs[i].ov));
    end

    // async reset mid-count
    drive(0, 0, 1, 5, 0, 1, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 1, 0);
    @(posedge clk); #1;
    chk("pre-rst dout", 32'(dout), 6);
    #2 rst = 1'b1;
    #1;
    chk("async rst dout", 32'(dout), 0);
    chk("async rst ovf",  32'(ovf),  0);
    up = 1'b0;
    #1;
    chk("tc zero latency down", 32'(tc), 1);
    up = 1'b1;
    #1;
    chk("tc zero latency up", 32'(tc), 0);
    @(posedge clk); #1;
    chk("rst held dout", 32'(dout), 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst step", 32'(dout), 1);
    chk("post-rst wrap", 32'(wrap), 0);
`else
    // prescaler DIV=3: steps on edges 3, 7, 10 with a load of 5 on edge 4
    begin
      logic [3:0] exp_ps [10];
      exp_ps = '{4'd0, 4'd0, 4'd1, 4'd5, 4'd5, 4'd5, 4'd6, 4'd6, 4'd6, 4'd7};
      for (int c = 0; c < 10; c++) begin
        drive(0, 0, (c == 3), 5, 1, 1, 0);
        @(posedge clk); #1;
        chk($sformatf("ps edge%0d dout", c+1), 32'(dout), 32'(exp_ps[c]));
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
